// File: rtl/tail_light_seq.sv
// Tail-light sequencer: per-side thermometer turn signals plus hazard flash,
// stepped by a prescaled tick, with all lamp outputs registered.
module tail_light_seq #(
  parameter int unsigned LAMPS = 3,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  output logic [LAMPS-1:0] la,
  output logic [LAMPS-1:0] ra,
  output logic             busy
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW = (LAMPS > 1) ? $clog2(LAMPS) : 1;
  localparam logic [PW-1:0] CNT_LAST  = PW'(DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(LAMPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEFT,
    ST_RIGHT,
    ST_HAZ
  } state_t;

  state_t           state;
  state_t           state_nx;
  // step holds k-1 for LEFT(k)/RIGHT(k)
  logic [SW-1:0]    step;
  logic [SW-1:0]    step_nx;
  logic [PW-1:0]    cnt;
  logic             tick_c;
  logic             haz_req_c;
  logic [LAMPS-1:0] bar_c;
  logic [LAMPS-1:0] la_nx;
  logic [LAMPS-1:0] ra_nx;
  logic             busy_nx;

  assign tick_c    = (cnt == CNT_LAST);
  assign haz_req_c = hazard | (left & right);

  // Prescaler: counts 0..DIV-1 and wraps; tick on the last count
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  // State and registered lamp outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      step  <= '0;
      la    <= '0;
      ra    <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      la    <= la_nx;
      ra    <= ra_nx;
      busy  <= busy_nx;
    end
  end

  // Next state on a tick; holds otherwise. Hazard preempts a running sequence,
  // but direction changes do not.
  always_comb begin
    state_nx = state;
    step_nx  = step;
    if (tick_c) begin
      case (state)
        ST_IDLE: begin
          step_nx = '0;
          if (haz_req_c)  state_nx = ST_HAZ;
          else if (left)  state_nx = ST_LEFT;
          else if (right) state_nx = ST_RIGHT;
          else            state_nx = ST_IDLE;
        end
        ST_LEFT, ST_RIGHT: begin
          if (haz_req_c) begin
            state_nx = ST_HAZ;
            step_nx  = '0;
          end else if (step == STEP_LAST) begin
            state_nx = ST_IDLE;
            step_nx  = '0;
          end else begin
            step_nx = step + SW'(1);
          end
        end
        ST_HAZ: begin
          state_nx = ST_IDLE;
          step_nx  = '0;
        end
        default: begin
          state_nx = ST_IDLE;
          step_nx  = '0;
        end
      endcase
    end
  end

  // Lamp pattern for the next state: k innermost lamps lit in LEFT/RIGHT(k)
  always_comb begin
    bar_c   = '0;
    la_nx   = '0;
    ra_nx   = '0;
    busy_nx = (state_nx != ST_IDLE);
    for (int i = 0; i < int'(LAMPS); i++) begin
      bar_c[i] = (SW'(i) <= step_nx);
    end
    case (state_nx)
      ST_LEFT:  la_nx = bar_c;
      ST_RIGHT: ra_nx = bar_c;
      ST_HAZ: begin
        la_nx = '1;
        ra_nx = '1;
      end
      default: begin
        la_nx = '0;
        ra_nx = '0;
      end
    endcase
  end

endmodule

// File: doc/tail_light_seq.md
TAIL_LIGHT_SEQ -- requirements
Module: tail_light_seq

Interface
REQ-001 Parameter LAMPS, default 3: lamps per side; legal range 1..8.
REQ-002 Parameter DIV, default 1: clock cycles per sequencer tick; legal range 1..65536.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 left  input  1  left-turn request, level-sensitive.
REQ-006 right  input  1  right-turn request, level-sensitive.
REQ-007 hazard  input  1  hazard request, level-sensitive.
REQ-008 la  output  LAMPS  left lamps; bit 0 innermost; registered.
REQ-009 ra  output  LAMPS  right lamps; bit 0 innermost; registered.
REQ-010 busy  output  1  high whenever state is not IDLE; registered.

Function
REQ-011 Prescaler counter, width max(1, clog2(DIV)), SHALL count 0..DIV-1 every cycle and wrap to 0; tick SHALL be high in the cycle the count equals DIV-1 (DIV=1: tick every cycle).
REQ-012 State and outputs SHALL change only on a clock edge where tick is high; otherwise they hold.
REQ-013 States: IDLE, LEFT(k), RIGHT(k) for k=1..LAMPS, HAZ_ON.
REQ-014 Request decode at a tick: haz_req = hazard | (left & right); priority haz_req > left > right.
REQ-015 IDLE: haz_req -> HAZ_ON; else left -> LEFT(1); else right -> RIGHT(1); else stay IDLE.
REQ-016 LEFT(k): la = (2^k)-1 (k innermost lamps lit), ra = 0; RIGHT(k) is symmetric on ra.
REQ-017 LEFT(k), k<LAMPS: tick -> LEFT(k+1); LEFT(LAMPS): tick -> IDLE. RIGHT is symmetric.
REQ-018 In LEFT/RIGHT, haz_req sampled at a tick SHALL abort the sequence and go to HAZ_ON on that edge.
REQ-019 Releasing left/right, or switching between them, mid-sequence SHALL NOT abort; the sequence runs to LEFT(LAMPS)/RIGHT(LAMPS), then IDLE, and requests are re-evaluated in IDLE.
REQ-020 HAZ_ON: la = ra = all ones; tick -> IDLE unconditionally.
REQ-021 IDLE: la = ra = 0.
REQ-022 Consequences: held left gives a period of LAMPS+1 ticks (LAMPS lit steps plus one dark step); held haz_req gives a period of 2 ticks.
REQ-023 Outputs SHALL be driven from registers with no combinational path from inputs.

Reset
REQ-024 reset high at a rising edge SHALL force state IDLE, la = 0, ra = 0, busy = 0 and prescaler = 0 on that edge, regardless of tick or requests.
REQ-025 Reset SHALL take priority over all request and tick activity, including mid-sequence.
REQ-026 After reset deasserts, the first tick SHALL occur DIV cycles later.

Verification (LAMPS=3, DIV=1 unless stated)
REQ-027 Reset held for 2 cycles with left=right=hazard=1 -> la=000, ra=000, busy=0 throughout.
REQ-028 left held -> la per cycle 001,011,111,000,001,...; ra=000; busy=1,1,1,0 in phase with the la sequence.
REQ-029 left=right=1 held -> la=ra toggling 111,000,111,...; identical behaviour with hazard=1 only.
REQ-030 right pulsed for 1 cycle from IDLE -> ra 001,011,111,000, then stays 000; busy returns to 0.
REQ-031 During left at la=011, hazard asserted -> next edge la=ra=111, following edge 000.
REQ-032 DIV=4, left held -> la changes only every 4th edge; reset pulse mid-sequence -> zeros on that edge, first new step 4 cycles after reset deasserts.
